// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, doubleword
// geometry and the legality check applied to every latched request.
package cpu_mem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } mem_state_t;

   localparam int DWORD_BYTES = 8;
   localparam int ALIGN_BITS  = 3;

   // Exactly one of load/store, doubleword aligned, and inside the array.
   function automatic logic is_legal_req(input logic        rd,
                                         input logic        wr,
                                         input logic [63:0] addr,
                                         input int unsigned depth);
      logic one_op;
      logic aligned;
      logic in_range;
      one_op   = rd ^ wr;
      aligned  = (addr[ALIGN_BITS-1:0] == '0);
      in_range = (addr < (64'(depth) * 64'(DWORD_BYTES)));
      return one_op && aligned && in_range;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous DEPTH x 64 doubleword store; contents are never reset.
module dmem_array #(
   parameter int DEPTH = 256,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [63:0]   wdata,
   output logic [63:0]   rdata
);

   logic [63:0] mem [DEPTH];

   // Read-before-write; the responder never forwards rdata for a store.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder with programmable latency between the CPU datapath and
// writeback: request handshake in, one array access, response handshake out.
module data_mem_responder
   import cpu_mem_pkg::*;
#(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2,
   parameter int ADDR_W  = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [ADDR_W-1:0] Address,
   input  logic [63:0]       Write_data,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [63:0]       Read_data,
   output logic              resp_err
);

   localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   mem_state_t        state, state_next;
   logic [3:0]        cnt;
   logic              rd_q, wr_q, err_q, load_q;
   logic [ADDR_W-1:0] addr_q;
   logic [63:0]       wdata_q;

   logic              accept, commit, array_we;
   logic              cur_rd, cur_wr, cur_legal;
   logic [ADDR_W-1:0] cur_addr;
   logic [63:0]       cur_wdata, arr_rdata;

   // With LATENCY==1 the access happens on the accepting edge straight from the
   // inputs; otherwise it uses the latched request on the last BUSY edge.
   always_comb begin
      accept    = req_valid && req_ready;
      cur_rd    = (state == IDLE) ? MemRead    : rd_q;
      cur_wr    = (state == IDLE) ? MemWrite   : wr_q;
      cur_addr  = (state == IDLE) ? Address    : addr_q;
      cur_wdata = (state == IDLE) ? Write_data : wdata_q;
      cur_legal = is_legal_req(cur_rd, cur_wr, 64'(cur_addr), DEPTH);
      commit    = ((state == BUSY) && (cnt <= 4'd1)) ||
                  ((state == IDLE) && accept && (LATENCY == 1));
      array_we  = commit && cur_wr && cur_legal;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (accept) state_next = (LATENCY == 1) ? RESP : BUSY;
         BUSY: if (commit) state_next = RESP;
         RESP: if (resp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      req_ready  = (state == IDLE) && !reset;
      resp_valid = (state == RESP);
      resp_err   = resp_valid && err_q;
      Read_data  = (resp_valid && load_q) ? arr_rdata : '0;
   end

   // Counter reaches zero on the commit edge; outcome flags are frozen there.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt     <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         load_q  <= 1'b0;
      end else begin
         if (accept) begin
            rd_q    <= MemRead;
            wr_q    <= MemWrite;
            addr_q  <= Address;
            wdata_q <= Write_data;
            cnt     <= CNT_LOAD;
         end else if (state == BUSY) begin
            cnt <= cnt - 4'd1;
         end
         if (commit) begin
            err_q  <= !cur_legal;
            load_q <= cur_rd && cur_legal;
         end
      end
   end

   dmem_array #(
      .DEPTH(DEPTH),
      .AW   (IDX_W)
   ) u_array (
      .clk  (clk),
      .we   (array_we),
      .addr (cur_addr[ALIGN_BITS +: IDX_W]),
      .wdata(cur_wdata),
      .rdata(arr_rdata)
   );

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Responder side of the CPU data-memory load/store interface. It accepts one load or store request at a time through a valid/ready handshake. It services the request against an internal doubleword array after a programmable latency, then returns read data and an error flag through a second valid/ready handshake. It sits between the CPU datapath (ALU address, register-file store data) and the writeback multiplexer. It replaces the zero-latency data memory so the core can be exercised against realistic memory timing.

Parameters:
DEPTH, 256, number of 64-bit doublewords in the array; byte address space is 0 to DEPTH*8-1
LATENCY, 2, cycles from request acceptance to resp_valid; legal range 1 to 15
ADDR_W, 64, request address width

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
MemRead  in  1  request is a load
MemWrite  in  1  request is a store
Address  in  ADDR_W  byte address; must be 8-byte aligned
Write_data  in  64  store data
resp_valid  out  1  response present
resp_ready  in  1  requester accepts the response
Read_data  out  64  load result; 0 for stores and errors
resp_err  out  1  request was illegal; no array side effect

Behaviour:
- Reset values: state IDLE, req_ready 0 while reset is high, resp_valid 0, Read_data 0, resp_err 0, latency counter 0.
- Array contents are not reset and are retained across reset.
- FSM states and transitions:
  - IDLE: req_ready=1. On req_valid&&req_ready, latch MemRead, MemWrite, Address and Write_data, load counter=LATENCY-1, go to BUSY. If LATENCY==1, go directly to RESP on the next edge.
  - BUSY: req_ready=0. Counter decrements each cycle. At counter==0, perform the access and go to RESP.
  - RESP: resp_valid=1, and Read_data and resp_err are held stable. On resp_ready, go to IDLE on the next edge.
- Latency: resp_valid rises exactly LATENCY cycles after the accepting edge.
- Throughput: at most one request per LATENCY+1 cycles, because the back-to-back accept happens in the cycle after the response handshake. req_ready never asserts in the same cycle as resp_valid.
- Error conditions, checked on the latched request:
  - MemRead and MemWrite both 1, or both 0.
  - Address[2:0] != 0.
  - Address[ADDR_W-1:3] >= DEPTH.
  - On error: resp_err=1, Read_data=0, no array write.
- Store: array[Address[..:3]] <= Write_data on the BUSY to RESP edge; Read_data=0, resp_err=0.
- Load: Read_data is captured from the array on the same edge.
- Inputs are ignored outside IDLE. req_valid held high during BUSY or RESP is not a second request; it is accepted only after returning to IDLE.
- resp_ready held high continuously: RESP lasts exactly one cycle.
- resp_ready low: RESP holds indefinitely with outputs stable.
- Reset mid-transaction (BUSY or RESP): abort immediately to IDLE, and resp_valid drops asynchronously.
  - A store whose commit edge has not occurred is not written.
  - A store already committed stays committed.
- Load from a word never written returns X in simulation. Benches preload the array via a hierarchical init task, or by stores.

Decomposition:
- Shared package (cpu_mem_pkg):
  - state encoding enum {IDLE, BUSY, RESP}.
  - constants DWORD_BYTES=8 and ALIGN_BITS=3.
  - function is_legal_req(rd, wr, addr, depth).
- One natural sub-module, dmem_array: a single-port synchronous DEPTH x 64 array with we, addr, wdata and rdata. The FSM, counter, error check and response registers stay in data_mem_responder.

Test Plan:
- Store then load, LATENCY=2: store Address=0x10, Write_data=0xDEADBEEF_CAFEF00D, resp_ready=1.
  - Expect resp_valid 2 cycles after accept, resp_err=0, Read_data=0.
  - Load 0x10 returns 0xDEADBEEF_CAFEF00D with resp_err=0.
- Backpressure: load 0x10 with resp_ready=0 for 5 cycles.
  - resp_valid and Read_data stay stable and req_ready stays 0.
  - Raise resp_ready: next cycle resp_valid=0 and req_ready=1.
- Errors:
  - Load Address=0x13 gives resp_err=1, Read_data=0.
  - Store Address=DEPTH*8=0x800 gives resp_err=1, and a later load of 0x0 is unchanged.
  - MemRead=MemWrite=1 gives resp_err=1.
- Back-to-back: req_valid held high with 3 loads queued by the bench, resp_ready=1.
  - Accepts occur every LATENCY+1=3 cycles.
  - Responses come back in order with correct data.
- Reset mid-store: store 0x20 <= 0x1234, then assert reset 1 cycle after accept (in BUSY).
  - resp_valid goes 0 immediately and req_ready goes 0.
  - After release, a load of 0x20 returns its prior preloaded value 0x0.
- LATENCY=1 build: load 0x8 gives resp_valid on the cycle after accept. The BUSY state is never entered, checked by an assertion.
